dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port data RAM between the processor's load/store port and a secondary debug/loader requester. The processor has priority. A starvation counter guarantees that the debug requester is served within a bounded number of cycles, and it does so by stalling the processor for one cycle. The block sits between the processor data-memory port and the RAM instance in the top-level wrapper. Memory-mapped I/O addresses are outside RAM and pass through untouched.

## Interface
- ADDR_WIDTH, 12: RAM word-address width.
- DATA_WIDTH, 32: data width.
- RAM_TOP, 4096: CPU addresses at or above this value are I/O, not RAM.
- STARVE_LIMIT, 4: number of consecutive denied debug cycles after which the CPU is stalled. Legal range 1-15.
- clock  in  1  single system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- cpu_rd_en  in  1  CPU load this cycle.
- cpu_wr_en  in  1  CPU store this cycle.
- cpu_addr  in  32  CPU byte/word address as issued by the processor.
- cpu_wdata  in  32  CPU store data.
- cpu_rdata  out  32  RAM read data to the CPU; equals ram_dataOut.
- cpu_stall  out  1  CPU must hold its access and retry next cycle.
- dbg_req  in  1  debug access request; held until granted.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  ADDR_WIDTH  debug word address.
- dbg_wdata  in  DATA_WIDTH  debug write data.
- dbg_gnt  out  1  access performed this cycle.
- dbg_rvalid  out  1  one-cycle pulse; dbg_rdata is valid.
- dbg_rdata  out  DATA_WIDTH  registered read data, held until the next debug read completes.
- ram_wEn  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_dataIn  out  DATA_WIDTH  RAM write data.
- ram_dataOut  in  DATA_WIDTH  RAM read data; 1-cycle latency after the address is presented.

## Operation
- cpu_ram = (cpu_rd_en | cpu_wr_en) & (cpu_addr < RAM_TOP). The comparison is a 32-bit unsigned compare.
- force = (starve_cnt == STARVE_LIMIT) & dbg_req.
- Owner selection, evaluated combinationally each cycle:
  - if cpu_ram & !force, the owner is CPU;
  - else if dbg_req, the owner is DBG;
  - else the block is IDLE.
- Owner CPU: ram_addr = cpu_addr[ADDR_WIDTH-1:0], ram_dataIn = cpu_wdata, ram_wEn = cpu_wr_en.
- Owner DBG: ram_addr = dbg_addr, ram_dataIn = dbg_wdata, ram_wEn = dbg_we, dbg_gnt = 1.
- IDLE: ram_addr = cpu_addr[ADDR_WIDTH-1:0], ram_wEn = 0.
- cpu_stall = force & cpu_ram. A CPU write is never committed in a stalled cycle. I/O accesses (addr >= RAM_TOP) are never stalled and never contend.
- starve_cnt (4 bits) update rules:
  - cleared when dbg_gnt = 1 or dbg_req = 0;
  - otherwise increments;
  - saturates at STARVE_LIMIT.
- rd_pending register: set when the owner is DBG and dbg_we = 0; otherwise cleared each cycle.
- When rd_pending is set, the next posedge captures dbg_rdata <= ram_dataOut and dbg_rvalid pulses for that cycle.
- Back-to-back debug accesses are allowed. The requester advances its address on each dbg_gnt, and every granted cycle is one complete access.
- The CPU read path is unchanged: cpu_rdata = ram_dataOut, with the same latency as a direct connection.

## Timing
- Reset values while reset = 0: starve_cnt = 0, rd_pending = 0, dbg_rvalid = 0, dbg_rdata = 0. Combinational outputs are forced to dbg_gnt = 0, cpu_stall = 0, ram_wEn = 0.
- dbg_gnt and cpu_stall are Mealy outputs, valid in the same cycle as the request.
- A write commits at the posedge that ends the grant cycle.
- Debug read latency: dbg_rvalid is high in the cycle after the dbg_gnt cycle.
- Worst-case debug wait under continuous CPU RAM traffic is STARVE_LIMIT denied cycles followed by a grant on cycle STARVE_LIMIT+1.
- Maximum CPU stall is 1 cycle per STARVE_LIMIT+1 cycles.
- Simultaneous events:
  - CPU RAM access and debug request with the counter below limit: the CPU wins and starve_cnt increments.
  - At the limit: the debug request wins, and the counter is 0 the next cycle, so the retried CPU access wins.
- dbg_req dropped before grant: the counter clears and no access occurs.
- Reset asserted mid-read: the pending dbg_rvalid is discarded; no pulse after release.
- Reset release: arbitration is live on the first posedge.

## Test plan
- Debug only: CPU idle, debug write 0xDEADBEEF to 0x010, then debug read 0x010 -> dbg_gnt is high in each request cycle; dbg_rvalid occurs 1 cycle after the read grant with dbg_rdata = 0xDEADBEEF.
- Starvation, STARVE_LIMIT = 4: CPU issues a load every cycle from 0x000, debug holds a read request -> 4 denied cycles; on the 5th, dbg_gnt = 1 and cpu_stall = 1 with ram_addr = dbg_addr; the CPU access is served on the next cycle with cpu_stall = 0.
- Stalled store suppressed: CPU stores 0x1234 to 0x020 in the forced cycle -> ram_wEn is taken from dbg_we; the store lands only on the retry cycle and RAM[0x020] = 0x1234 afterwards.
- I/O bypass: CPU store to address 4097 every cycle while the debug port requests -> the debug request is granted every cycle, cpu_stall stays 0 and starve_cnt stays 0.
- Async reset mid-read: assert reset in the cycle after a debug read grant -> dbg_rvalid stays 0, dbg_rdata = 0 and starve_cnt = 0; the first request after release is granted normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU load/store port and a debug/loader requester.
// The CPU has priority; a starvation counter forces a one-cycle CPU stall to serve debug.
module dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned RAM_TOP      = 4096,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cpu_rd_en_i,
  input  logic                  cpu_wr_en_i,
  input  logic [31:0]           cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  output logic                  cpu_stall_o,
  input  logic                  dbg_req_i,
  input  logic                  dbg_we_i,
  input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
  input  logic [DATA_WIDTH-1:0] dbg_wdata_i,
  output logic                  dbg_gnt_o,
  output logic                  dbg_rvalid_o,
  output logic [DATA_WIDTH-1:0] dbg_rdata_o,
  output logic                  ram_wen_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_in_o,
  input  logic [DATA_WIDTH-1:0] ram_data_out_i
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {OwnIdle, OwnCpu, OwnDbg} owner_e;

  owner_e                owner;
  logic                  cpu_ram;
  logic                  force_dbg;
  logic                  dbg_gnt;
  logic [3:0]            starve_q, starve_d;
  logic                  rd_pending_q, rd_pending_d;
  logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;

  // I/O addresses never touch the RAM and therefore never contend.
  assign cpu_ram   = (cpu_rd_en_i | cpu_wr_en_i) & (cpu_addr_i < 32'(RAM_TOP));
  assign force_dbg = (starve_q == Limit) & dbg_req_i;

  always_comb begin
    owner = OwnIdle;
    if (cpu_ram && !force_dbg) begin
      owner = OwnCpu;
    end else if (dbg_req_i) begin
      owner = OwnDbg;
    end
  end

  assign dbg_gnt = (owner == OwnDbg);

  always_comb begin
    ram_addr_o    = cpu_addr_i[ADDR_WIDTH-1:0];
    ram_data_in_o = cpu_wdata_i;
    ram_wen_o     = 1'b0;
    dbg_gnt_o     = 1'b0;
    unique case (owner)
      OwnCpu: ram_wen_o = cpu_wr_en_i;
      OwnDbg: begin
        ram_addr_o    = dbg_addr_i;
        ram_data_in_o = dbg_wdata_i;
        ram_wen_o     = dbg_we_i;
        dbg_gnt_o     = 1'b1;
      end
      default: ;
    endcase
    cpu_stall_o = force_dbg & cpu_ram;
    if (!rst_ni) begin
      ram_wen_o   = 1'b0;
      dbg_gnt_o   = 1'b0;
      cpu_stall_o = 1'b0;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (dbg_gnt || !dbg_req_i) begin
      starve_d = '0;
    end else if (starve_q != Limit) begin
      starve_d = starve_q + 4'd1;
    end
    rd_pending_d = dbg_gnt & ~dbg_we_i;
    dbg_rdata_d  = rd_pending_q ? ram_data_out_i : dbg_rdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q     <= '0;
      rd_pending_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      starve_q     <= starve_d;
      rd_pending_q <= rd_pending_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // RAM data arrives the cycle after the grant; pass it through then and hold it afterwards.
  assign dbg_rvalid_o = rd_pending_q;
  assign dbg_rdata_o  = rd_pending_q ? ram_data_out_i : dbg_rdata_q;
  assign cpu_rdata_o  = ram_data_out_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1-cycle-latency RAM and a
// scoreboard queue of expected debug read data.
module tb_dmem_arbiter;

  logic        clk_i;
  logic        rst_ni;
  logic        cpu_rd_en, cpu_wr_en;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req, dbg_we;
  logic [11:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        ram_wen;
  logic [11:0] ram_addr;
  logic [31:0] ram_din, ram_dout;

  logic [31:0] mem [4096];
  logic [31:0] exp_q[$];
  int          tests;
  int          fails;

  dmem_arbiter #(
    .ADDR_WIDTH  (12),
    .DATA_WIDTH  (32),
    .RAM_TOP     (4096),
    .STARVE_LIMIT(4)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .cpu_rd_en_i   (cpu_rd_en),
    .cpu_wr_en_i   (cpu_wr_en),
    .cpu_addr_i    (cpu_addr),
    .cpu_wdata_i   (cpu_wdata),
    .cpu_rdata_o   (cpu_rdata),
    .cpu_stall_o   (cpu_stall),
    .dbg_req_i     (dbg_req),
    .dbg_we_i      (dbg_we),
    .dbg_addr_i    (dbg_addr),
    .dbg_wdata_i   (dbg_wdata),
    .dbg_gnt_o     (dbg_gnt),
    .dbg_rvalid_o  (dbg_rvalid),
    .dbg_rdata_o   (dbg_rdata),
    .ram_wen_o     (ram_wen),
    .ram_addr_o    (ram_addr),
    .ram_data_in_o (ram_din),
    .ram_data_out_i(ram_dout)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Read-first single-port RAM with one cycle of read latency.
  always @(posedge clk_i) begin
    if (ram_wen) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Every dbg_rvalid pulse must match the oldest outstanding expected read.
  always @(negedge clk_i) begin
    if (dbg_rvalid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL rvalid_unexpected: observed rvalid=1 expected rvalid=0");
      end else begin
        chk("dbg_rdata_sb", dbg_rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_ni = 1'b0;
    cpu_rd_en = 1'b0; cpu_wr_en = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 12'h10; dbg_wdata = 32'h2;

    // Reset: Mealy outputs forced low even with requests present.
    #3;
    chk("rst_gnt", 32'(dbg_gnt), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_wen", 32'(ram_wen), 32'd0);
    chk("rst_rvalid", 32'(dbg_rvalid), 32'd0);
    chk("rst_rdata", dbg_rdata, 32'd0);
    tick();
    chk("rst_gnt_edge", 32'(dbg_gnt), 32'd0);
    rst_ni = 1'b1;
    cpu_wr_en = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;

    // Debug only: write then read back.
    tick();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 12'h010; dbg_wdata = 32'hDEADBEEF;
    #2;
    chk("t1_wr_gnt", 32'(dbg_gnt), 32'd1);
    chk("t1_wr_wen", 32'(ram_wen), 32'd1);
    chk("t1_wr_addr", 32'(ram_addr), 32'h010);
    chk("t1_wr_din", ram_din, 32'hDEADBEEF);
    tick();
    dbg_we = 1'b0;
    #2;
    chk("t1_rd_gnt", 32'(dbg_gnt), 32'd1);
    chk("t1_rd_wen", 32'(ram_wen), 32'd0);
    exp_q.push_back(32'hDEADBEEF);
    tick();
    dbg_req = 1'b0;
    #2;
    chk("t1_rvalid", 32'(dbg_rvalid), 32'd1);
    chk("t1_idle_gnt", 32'(dbg_gnt), 32'd0);
    tick();
    #2;
    chk("t1_rvalid_pulse", 32'(dbg_rvalid), 32'd0);
    chk("t1_rdata_hold", dbg_rdata, 32'hDEADBEEF);

    // Starvation: CPU loads every cycle, debug read waits four cycles.
    tick();
    cpu_rd_en = 1'b1; cpu_addr = 32'h0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 12'h010;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("t2_denied_gnt", 32'(dbg_gnt), 32'd0);
      chk("t2_denied_stall", 32'(cpu_stall), 32'd0);
      chk("t2_denied_addr", 32'(ram_addr), 32'h000);
      tick();
    end
    #2;
    chk("t2_force_gnt", 32'(dbg_gnt), 32'd1);
    chk("t2_force_stall", 32'(cpu_stall), 32'd1);
    chk("t2_force_addr", 32'(ram_addr), 32'h010);
    exp_q.push_back(32'hDEADBEEF);
    tick();
    dbg_req = 1'b0;
    #2;
    chk("t2_retry_stall", 32'(cpu_stall), 32'd0);
    chk("t2_retry_addr", 32'(ram_addr), 32'h000);
    chk("t2_rvalid", 32'(dbg_rvalid), 32'd1);

    // Stalled store is suppressed and lands on the retry cycle.
    tick();
    cpu_rd_en = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 12'h020; dbg_wdata = 32'h55555555;
    #2;
    chk("t3_preload_gnt", 32'(dbg_gnt), 32'd1);
    tick();
    cpu_rd_en = 1'b1; cpu_addr = 32'h0;
    dbg_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("t3_denied_gnt", 32'(dbg_gnt), 32'd0);
      tick();
    end
    cpu_rd_en = 1'b0; cpu_wr_en = 1'b1; cpu_addr = 32'h020; cpu_wdata = 32'h1234;
    #2;
    chk("t3_force_stall", 32'(cpu_stall), 32'd1);
    chk("t3_force_gnt", 32'(dbg_gnt), 32'd1);
    chk("t3_force_wen", 32'(ram_wen), 32'd0);
    exp_q.push_back(32'h55555555);
    tick();
    dbg_req = 1'b0;
    #2;
    chk("t3_retry_stall", 32'(cpu_stall), 32'd0);
    chk("t3_retry_wen", 32'(ram_wen), 32'd1);
    chk("t3_retry_addr", 32'(ram_addr), 32'h020);
    chk("t3_retry_din", ram_din, 32'h1234);
    tick();
    cpu_wr_en = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 12'h020;
    #2;
    chk("t3_rb_gnt", 32'(dbg_gnt), 32'd1);
    exp_q.push_back(32'h1234);
    tick();
    dbg_req = 1'b0;
    #2;
    chk("t3_rb_rvalid", 32'(dbg_rvalid), 32'd1);

    // I/O bypass: CPU stores to I/O never contend with debug.
    tick();
    cpu_wr_en = 1'b1; cpu_addr = 32'd4097; cpu_wdata = 32'hCAFE;
    dbg_req = 1'b1; dbg_we = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dbg_addr = 12'(12'h030 + i);
      dbg_wdata = 32'hA0 + 32'(i);
      #2;
      chk("t4_io_gnt", 32'(dbg_gnt), 32'd1);
      chk("t4_io_stall", 32'(cpu_stall), 32'd0);
      chk("t4_io_wen", 32'(ram_wen), 32'd1);
      chk("t4_io_addr", 32'(ram_addr), 32'h030 + 32'(i));
      tick();
    end
    // Counter must still be 0: a full four denied cycles before the forced grant.
    cpu_wr_en = 1'b0; cpu_rd_en = 1'b1; cpu_addr = 32'h0;
    dbg_we = 1'b0; dbg_addr = 12'h035;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("t4_cnt_denied", 32'(dbg_gnt), 32'd0);
      tick();
    end
    #2;
    chk("t4_cnt_force", 32'(dbg_gnt), 32'd1);
    exp_q.push_back(32'hA5);
    tick();
    dbg_req = 1'b0; cpu_rd_en = 1'b0; cpu_wr_en = 1'b1; cpu_addr = 32'd4097;
    #2;
    chk("t4_io_idle_wen", 32'(ram_wen), 32'd0);
    chk("t4_io_idle_stall", 32'(cpu_stall), 32'd0);
    chk("t4_io_rvalid", 32'(dbg_rvalid), 32'd1);
    tick();
    cpu_addr = 32'd4096;
    #2;
    chk("t4_top_wen", 32'(ram_wen), 32'd0);
    tick();
    cpu_addr = 32'd4095; cpu_wdata = 32'h77;
    #2;
    chk("t4_below_top_wen", 32'(ram_wen), 32'd1);
    chk("t4_below_top_addr", 32'(ram_addr), 32'hFFF);

    // Async reset in the cycle after a read grant discards the pending pulse.
    tick();
    cpu_wr_en = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 12'h020;
    #2;
    chk("t5_gnt", 32'(dbg_gnt), 32'd1);
    tick();
    dbg_req = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("t5_rst_rvalid", 32'(dbg_rvalid), 32'd0);
    chk("t5_rst_rdata", dbg_rdata, 32'd0);
    tick();
    #2;
    rst_ni = 1'b1;
    tick();
    #2;
    chk("t5_post_rvalid", 32'(dbg_rvalid), 32'd0);
    cpu_rd_en = 1'b1; cpu_addr = 32'h0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 12'h010;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("t5_post_denied", 32'(dbg_gnt), 32'd0);
      tick();
    end
    #2;
    chk("t5_post_gnt", 32'(dbg_gnt), 32'd1);
    exp_q.push_back(32'hDEADBEEF);
    tick();
    dbg_req = 1'b0; cpu_rd_en = 1'b0;
    #2;
    chk("t5_post_rd_rvalid", 32'(dbg_rvalid), 32'd1);
    tick();
    #2;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
